// File: rtl/seg_display_arbiter_pkg.sv
// Shared constants for the seven-segment display arbiter: FSM encoding, blank codes,
// anode scan patterns and the active-low segment decode table (bit 7 = dp, bits 6:0 = a..g).
package seg_display_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } arb_state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [7:0] SEG_OFF    = 8'hFF;

    localparam logic [3:0] ANODE_OFF  = 4'b1111;
    localparam logic [3:0] ANODE_DIG0 = 4'b0111;
    localparam logic [3:0] ANODE_DIG1 = 4'b1011;
    localparam logic [3:0] ANODE_DIG2 = 4'b1101;
    localparam logic [3:0] ANODE_DIG3 = 4'b1110;

    localparam logic [7:0] SEG_D0 = 8'b1000_0001;
    localparam logic [7:0] SEG_D1 = 8'b1100_1111;
    localparam logic [7:0] SEG_D2 = 8'b1001_0010;
    localparam logic [7:0] SEG_D3 = 8'b1000_0110;
    localparam logic [7:0] SEG_D4 = 8'b1100_1100;
    localparam logic [7:0] SEG_D5 = 8'b1010_0100;
    localparam logic [7:0] SEG_D6 = 8'b1010_0000;
    localparam logic [7:0] SEG_D7 = 8'b1000_1111;
    localparam logic [7:0] SEG_D8 = 8'b1000_0000;
    localparam logic [7:0] SEG_D9 = 8'b1000_0100;

    function automatic logic [3:0] anode_pattern(input logic [1:0] idx);
        case (idx)
            2'd0:    return ANODE_DIG0;
            2'd1:    return ANODE_DIG1;
            2'd2:    return ANODE_DIG2;
            default: return ANODE_DIG3;
        endcase
    endfunction

endpackage

// File: rtl/seg_bcd_decoder.sv
// BCD to active-low seven-segment decoder; purely combinational, zero latency, no handshake.
// Codes 10-15 blank the digit; the decimal point is never lit.
module seg_bcd_decoder
    import seg_display_arbiter_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (value_i)
            4'd0:    seg_o = SEG_D0;
            4'd1:    seg_o = SEG_D1;
            4'd2:    seg_o = SEG_D2;
            4'd3:    seg_o = SEG_D3;
            4'd4:    seg_o = SEG_D4;
            4'd5:    seg_o = SEG_D5;
            4'd6:    seg_o = SEG_D6;
            4'd7:    seg_o = SEG_D7;
            4'd8:    seg_o = SEG_D8;
            4'd9:    seg_o = SEG_D9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin write arbiter for four display digit registers plus the refresh scan; a write
// is acknowledged 2 cycles after valid, at most one write per 2 cycles, clear overrides writes.
// Optional SEG_BLINK_EN adds blink_mask and a slow blink counter that blanks masked digits.
module seg_display_arbiter
    import seg_display_arbiter_pkg::*;
#(
    parameter int CYCLE_BITS = 21,
    parameter int SCAN_CYCLE = 400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [1:0]  req0_digit,
    input  logic [3:0]  req0_value,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_digit,
    input  logic [3:0]  req1_value,
    output logic        req1_ready,
    input  logic        clear,
    output logic [15:0] digits,
    output logic        last_grant,
    output logic [3:0]  anodeOutput,
    output logic [7:0]  cathodeOutput
`ifdef SEG_BLINK_EN
    ,
    input  logic [3:0]  blink_mask
`endif
);

    arb_state_t            state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic [15:0]           digits_q, digits_d;
    logic [CYCLE_BITS-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]            scan_idx_q, scan_idx_d;
    logic [3:0]            anode_q, anode_d;
    logic [7:0]            cathode_q, cathode_d;

    logic                  eff_v0, eff_v1;
    logic                  gnt_vld;
    logic [1:0]            gnt_digit;
    logic [3:0]            gnt_value;
    logic                  scan_tick;
    logic [3:0]            cur_code;
    logic [7:0]            cur_seg;
    logic                  blank_now;

    // A requester whose ready is up this cycle is completing now; it must not be re-granted.
    assign eff_v0    = req0_valid & ~rdy0_q;
    assign eff_v1    = req1_valid & ~rdy1_q;
    assign gnt_vld   = gnt_q ? req1_valid : req0_valid;
    assign gnt_digit = gnt_q ? req1_digit : req0_digit;
    assign gnt_value = gnt_q ? req1_value : req0_value;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        rdy0_d       = 1'b0;
        rdy1_d       = 1'b0;
        digits_d     = digits_q;
        case (state_q)
            ST_IDLE: begin
                if (eff_v0 || eff_v1) begin
                    state_d = ST_WRITE;
                    gnt_d   = (eff_v0 && eff_v1) ? ~last_grant_q : eff_v1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (!clear && gnt_vld) begin
                    rdy0_d       = ~gnt_q;
                    rdy1_d       = gnt_q;
                    last_grant_d = gnt_q;
                    digits_d[{gnt_digit, 2'b00} +: 4] = gnt_value;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            digits_d = {4{BLANK_CODE}};
        end
    end

    assign scan_tick  = (scan_cnt_q == CYCLE_BITS'(SCAN_CYCLE - 1));
    assign scan_cnt_d = scan_tick ? '0 : scan_cnt_q + CYCLE_BITS'(1);
    assign scan_idx_d = scan_tick ? scan_idx_q + 2'd1 : scan_idx_q;
    assign cur_code   = digits_q[{scan_idx_q, 2'b00} +: 4];

    seg_bcd_decoder u_dec (
        .value_i (cur_code),
        .seg_o   (cur_seg)
    );

`ifdef SEG_BLINK_EN
    logic [5:0] blink_cnt_q, blink_cnt_d;

    assign blink_cnt_d = (scan_tick && scan_idx_q == 2'd3) ? blink_cnt_q + 6'd1 : blink_cnt_q;
    assign blank_now   = blink_cnt_q[5] & blink_mask[scan_idx_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end
`else
    assign blank_now = 1'b0;
`endif

    assign anode_d   = anode_pattern(scan_idx_q);
    assign cathode_d = blank_now ? SEG_OFF : cur_seg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rdy0_q       <= 1'b0;
            rdy1_q       <= 1'b0;
            digits_q     <= {4{BLANK_CODE}};
            scan_cnt_q   <= '0;
            scan_idx_q   <= '0;
            anode_q      <= ANODE_OFF;
            cathode_q    <= SEG_OFF;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            rdy0_q       <= rdy0_d;
            rdy1_q       <= rdy1_d;
            digits_q     <= digits_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
        end
    end

    assign req0_ready    = rdy0_q;
    assign req1_ready    = rdy1_q;
    assign digits        = digits_q;
    assign last_grant    = last_grant_q;
    assign anodeOutput   = anode_q;
    assign cathodeOutput = cathode_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter with a 4-cycle scan; digit contents, grant order and scan
// outputs are predicted from a small array model of the display and elapsed-cycle arithmetic.
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0]  req0_digit = '0, req1_digit = '0;
    logic [3:0]  req0_value = '0, req1_value = '0;
    logic        req0_ready, req1_ready;
    logic        clear = 1'b0;
    logic [15:0] digits;
    logic        last_grant;
    logic [3:0]  anodeOutput;
    logic [7:0]  cathodeOutput;
`ifdef SEG_BLINK_EN
    logic [3:0]  blink_mask = 4'b0000;
`endif

    int          cmp = 0;
    int          err = 0;
    int          edges;
    logic [3:0]  mdl [4];
    logic        mdl_lg;

    seg_display_arbiter #(.CYCLE_BITS(21), .SCAN_CYCLE(4)) dut (
`ifdef SEG_BLINK_EN
        .blink_mask    (blink_mask),
`endif
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_digit    (req0_digit),
        .req0_value    (req0_value),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_digit    (req1_digit),
        .req1_value    (req1_value),
        .req1_ready    (req1_ready),
        .clear         (clear),
        .digits        (digits),
        .last_grant    (last_grant),
        .anodeOutput   (anodeOutput),
        .cathodeOutput (cathodeOutput)
    );

    always #5 clk = ~clk;

    // Clock edges seen since the last reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_seg(input logic [3:0] v);
        case (v)
            4'd0: return 8'b10000001;
            4'd1: return 8'b11001111;
            4'd2: return 8'b10010010;
            4'd3: return 8'b10000110;
            4'd4: return 8'b11001100;
            4'd5: return 8'b10100100;
            4'd6: return 8'b10100000;
            4'd7: return 8'b10001111;
            4'd8: return 8'b10000000;
            4'd9: return 8'b10000100;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [3:0] exp_an(input int idx);
        logic [3:0] pats [4];
        pats[0] = 4'b0111; pats[1] = 4'b1011; pats[2] = 4'b1101; pats[3] = 4'b1110;
        return pats[idx % 4];
    endfunction

    function automatic logic [15:0] mdl_packed();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    task automatic mdl_blank();
        for (int i = 0; i < 4; i++) mdl[i] = 4'hF;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one write and waits for its ready; lat is the edge count to ready or -1.
    task automatic drive_write(input int r, input logic [1:0] d, input logic [3:0] v, output int lat);
        lat = -1;
        if (r == 0) begin req0_valid = 1'b1; req0_digit = d; req0_value = v; end
        else        begin req1_valid = 1'b1; req1_digit = d; req1_value = v; end
        for (int n = 1; n <= 10; n++) begin
            step();
            if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin
                lat = n;
                break;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        mdl_blank();
        mdl_lg = 1'b1;
        #2;
        cmp++; if (digits !== 16'hFFFF) begin err++; $display("FAIL reset_digits got=%h exp=ffff", digits); end
        cmp++; if (anodeOutput !== 4'b1111) begin err++; $display("FAIL reset_anode got=%b exp=1111", anodeOutput); end
        cmp++; if (cathodeOutput !== 8'hFF) begin err++; $display("FAIL reset_cathode got=%h exp=ff", cathodeOutput); end
        cmp++; if ({req0_ready, req1_ready, last_grant} !== 3'b001) begin
            err++; $display("FAIL reset_handshake got=%b exp=001", {req0_ready, req1_ready, last_grant});
        end
        step();
        step();
        rst = 1'b1;
        cmp++; if (anodeOutput !== 4'b1111) begin err++; $display("FAIL release_anode got=%b exp=1111", anodeOutput); end
        for (int k = 1; k <= 20; k++) begin
            step();
            cmp++;
            if (anodeOutput !== exp_an((k - 1) / 4) || cathodeOutput !== 8'hFF) begin
                err++;
                $display("FAIL scan_after_reset k=%0d got=%b/%h exp=%b/ff", k, anodeOutput, cathodeOutput, exp_an((k - 1) / 4));
            end
        end
    endtask

    task automatic test_write();
        int lat;
        int found;
        drive_write(0, 2'd2, 4'd5, lat);
        cmp++; if (lat != 2) begin err++; $display("FAIL write_latency got=%0d exp=2", lat); end
        mdl[2] = 4'd5;
        mdl_lg = 1'b0;
        cmp++; if (digits !== mdl_packed()) begin err++; $display("FAIL write_digits got=%h exp=%h", digits, mdl_packed()); end
        step();
        cmp++; if (req0_ready !== 1'b0) begin err++; $display("FAIL write_ready_width got=%b exp=0", req0_ready); end
        cmp++; if (last_grant !== 1'b0) begin err++; $display("FAIL write_last_grant got=%b exp=0", last_grant); end
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            step();
            if (anodeOutput === 4'b1101) found = 1;
        end
        cmp++; if (found == 0 || cathodeOutput !== 8'b10100100) begin
            err++; $display("FAIL write_cathode found=%0d got=%b exp=10100100", found, cathodeOutput);
        end
    endtask

    task automatic test_contention();
        int exp_id, last_t, got, id;
        logic [1:0] d0, d1;
        logic [3:0] v0, v1;
        d0 = 2'd0; v0 = 4'd1; d1 = 2'd1; v1 = 4'd2;
        req0_digit = d0; req0_value = v0; req1_digit = d1; req1_value = v1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_id = mdl_lg ? 0 : 1;
        got = 0; last_t = 0;
        for (int t = 1; t <= 60 && got < 10; t++) begin
            step();
            if (req0_ready && req1_ready) begin
                cmp++; err++; $display("FAIL contention_both_ready t=%0d", t);
            end else if (req0_ready || req1_ready) begin
                id = req1_ready ? 1 : 0;
                cmp++; if (id != exp_id) begin err++; $display("FAIL contention_order got=%0d exp=%0d", id, exp_id); end
                cmp++; if (t - last_t != 2) begin err++; $display("FAIL contention_spacing got=%0d exp=2", t - last_t); end
                last_t = t;
                if (id == 0) mdl[d0] = v0; else mdl[d1] = v1;
                mdl_lg = id[0];
                exp_id = 1 - id;
                cmp++; if (digits !== mdl_packed()) begin err++; $display("FAIL contention_digits got=%h exp=%h", digits, mdl_packed()); end
                cmp++; if (last_grant !== mdl_lg) begin err++; $display("FAIL contention_last_grant got=%b exp=%b", last_grant, mdl_lg); end
                if (got >= 3) begin
                    if (id == 0) begin d0 = 2'($urandom_range(0, 3)); v0 = 4'($urandom_range(0, 15)); req0_digit = d0; req0_value = v0; end
                    else         begin d1 = 2'($urandom_range(0, 3)); v1 = 4'($urandom_range(0, 15)); req1_digit = d1; req1_value = v1; end
                end
                got++;
            end
        end
        cmp++; if (got < 10) begin err++; $display("FAIL contention_timeout got=%0d exp=10", got); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        step();
        cmp++; if (digits !== mdl_packed()) begin err++; $display("FAIL contention_end_digits got=%h exp=%h", digits, mdl_packed()); end
    endtask

    task automatic test_withdraw();
        req1_digit = 2'd3; req1_value = 4'd7; req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            cmp++; if (req1_ready !== 1'b0) begin err++; $display("FAIL withdraw_ready n=%0d got=%b exp=0", n, req1_ready); end
        end
        cmp++; if (digits !== mdl_packed()) begin err++; $display("FAIL withdraw_digits got=%h exp=%h", digits, mdl_packed()); end
        cmp++; if (last_grant !== mdl_lg) begin err++; $display("FAIL withdraw_last_grant got=%b exp=%b", last_grant, mdl_lg); end
    endtask

    task automatic test_clear();
        req0_digit = 2'd1; req0_value = 4'd9; req0_valid = 1'b1;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        mdl_blank();
        cmp++; if (req0_ready !== 1'b0) begin err++; $display("FAIL clear_ready got=%b exp=0", req0_ready); end
        cmp++; if (digits !== 16'hFFFF) begin err++; $display("FAIL clear_digits got=%h exp=ffff", digits); end
        step();
        cmp++; if (req0_ready !== 1'b0) begin err++; $display("FAIL clear_regrant_early got=%b exp=0", req0_ready); end
        step();
        cmp++; if (req0_ready !== 1'b1) begin err++; $display("FAIL clear_regrant got=%b exp=1", req0_ready); end
        req0_valid = 1'b0;
        mdl[1] = 4'd9;
        mdl_lg = 1'b0;
        cmp++; if (digits !== mdl_packed()) begin err++; $display("FAIL clear_new_value got=%h exp=%h", digits, mdl_packed()); end
        step();
    endtask

    task automatic test_random_writes();
        int lat, r;
        logic [1:0] d;
        logic [3:0] v;
        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 1));
            d = 2'($urandom_range(0, 3));
            v = 4'($urandom_range(0, 15));
            drive_write(r, d, v, lat);
            mdl[d] = v;
            mdl_lg = r[0];
            cmp++; if (lat != 2) begin err++; $display("FAIL random_latency i=%0d got=%0d exp=2", i, lat); end
            cmp++; if (digits !== mdl_packed() || last_grant !== mdl_lg) begin
                err++; $display("FAIL random_state i=%0d got=%h/%b exp=%h/%b", i, digits, last_grant, mdl_packed(), mdl_lg);
            end
            step();
        end
        for (int n = 0; n < 16; n++) begin
            step();
            cmp++;
            if (anodeOutput !== exp_an((edges - 1) / 4) || cathodeOutput !== exp_seg(mdl[((edges - 1) / 4) % 4])) begin
                err++;
                $display("FAIL random_scan got=%b/%b exp=%b/%b", anodeOutput, cathodeOutput,
                         exp_an((edges - 1) / 4), exp_seg(mdl[((edges - 1) / 4) % 4]));
            end
        end
    endtask

    task automatic test_decode();
        int lat, r, found;
        for (int v = 0; v < 16; v++) begin
            r = int'($urandom_range(0, 1));
            drive_write(r, 2'd0, 4'(v), lat);
            mdl[0] = 4'(v);
            mdl_lg = r[0];
            step();
            found = 0;
            for (int n = 0; n < 20 && found == 0; n++) begin
                step();
                if (anodeOutput === 4'b0111) found = 1;
            end
            cmp++; if (lat != 2 || found == 0 || cathodeOutput !== exp_seg(4'(v))) begin
                err++; $display("FAIL decode v=%0d lat=%0d found=%0d got=%b exp=%b", v, lat, found, cathodeOutput, exp_seg(4'(v)));
            end
        end
    endtask

    task automatic test_async_reset();
        int found, lat;
        found = 0;
        for (int n = 0; n < 30 && found == 0; n++) begin
            step();
            if (anodeOutput === 4'b1101) found = 1;
        end
        cmp++; if (found == 0) begin err++; $display("FAIL areset_find_index2 got=%b exp=1101", anodeOutput); end
        #2 rst = 1'b0;
        #1;
        mdl_blank();
        mdl_lg = 1'b1;
        cmp++; if (anodeOutput !== 4'b1111 || cathodeOutput !== 8'hFF || digits !== 16'hFFFF || last_grant !== 1'b1) begin
            err++; $display("FAIL areset_outputs got=%b/%h/%h/%b exp=1111/ff/ffff/1", anodeOutput, cathodeOutput, digits, last_grant);
        end
        step();
        rst = 1'b1;
        step();
        cmp++; if (anodeOutput !== 4'b0111) begin err++; $display("FAIL areset_restart got=%b exp=0111", anodeOutput); end
        for (int n = 0; n < 4; n++) step();
        cmp++; if (anodeOutput !== 4'b1011) begin err++; $display("FAIL areset_second_digit got=%b exp=1011", anodeOutput); end
        drive_write(0, 2'd3, 4'd4, lat);
        cmp++; if (lat != 2 || req0_ready !== 1'b1) begin err++; $display("FAIL areset_write_setup lat=%0d ready=%b", lat, req0_ready); end
        #2 rst = 1'b0;
        #1;
        cmp++; if (req0_ready !== 1'b0 || digits !== 16'hFFFF) begin
            err++; $display("FAIL areset_mid_write got=%b/%h exp=0/ffff", req0_ready, digits);
        end
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_contention();
        test_withdraw();
        test_clear();
        test_random_writes();
        test_decode();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
